// File: rtl/periph_handshake_rx_if.sv
// Signal bundle for the peripheral end of the 4-phase send/ack link and its FWFT read port.
// acc_sum is present only when PERIPH_ACCUM_EN is defined.
interface periph_handshake_rx_if #(
   parameter int DW = 16,
   parameter int AW = 2
);
   logic [DW-1:0] dado;
   logic          send;
   logic          ack;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          empty;
   logic          full;
   logic [AW:0]   count;
   logic          stall;
   logic [15:0]   rx_total;
`ifdef PERIPH_ACCUM_EN
   logic [DW-1:0] acc_sum;
`endif

   modport master (
      output dado, send, rd_en,
      input  ack, rd_data, empty, full, count, stall, rx_total
`ifdef PERIPH_ACCUM_EN
      , acc_sum
`endif
   );

   modport slave (
      input  dado, send, rd_en,
      output ack, rd_data, empty, full, count, stall, rx_total
`ifdef PERIPH_ACCUM_EN
      , acc_sum
`endif
   );
endinterface

// File: rtl/periph_handshake_rx.sv
// Responder end of the 4-phase send/ack link: synchronizes send, captures dado into a FWFT FIFO.
// Optional running sum of captured words when PERIPH_ACCUM_EN is defined.
module periph_handshake_rx #(
   parameter int DW    = 16,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input logic                 clk,
   input logic                 rst,
   periph_handshake_rx_if.slave bus
);
   typedef enum logic {IDLE, ACK} state_t;

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic          r_send_meta, r_send_s;
   state_t        r_state, w_state_nxt;
   logic          w_wr, w_rd, w_stall;
   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   logic [15:0]   r_rx_total;
   logic          w_full, w_empty;

   assign w_full  = (r_count == FULL_CNT);
   assign w_empty = (r_count == '0);
   assign w_rd    = bus.rd_en && !w_empty;

   // send crosses from the initiator's domain; dado is held stable by protocol, so it is not synchronized
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_send_meta <= 1'b0;
         r_send_s    <= 1'b0;
      end else begin
         r_send_meta <= bus.send;
         r_send_s    <= r_send_meta;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_wr        = 1'b0;
      w_stall     = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_send_s) begin
               if (!w_full) begin
                  w_wr        = 1'b1;
                  w_state_nxt = ACK;
               end else begin
                  w_stall = 1'b1;
               end
            end
         end
         ACK: begin
            if (!r_send_s) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_rx_total <= '0;
      end else begin
         if (w_wr) begin
            r_mem[r_wr_ptr] <= bus.dado;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
            r_rx_total      <= r_rx_total + 16'd1;
         end
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef PERIPH_ACCUM_EN
   logic [DW-1:0] r_acc_sum;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      r_acc_sum <= '0;
      else if (w_wr) r_acc_sum <= r_acc_sum + bus.dado;
   end
   assign bus.acc_sum = r_acc_sum;
`endif

   assign bus.ack      = (r_state == ACK);
   assign bus.rd_data  = r_mem[r_rd_ptr];
   assign bus.empty    = w_empty;
   assign bus.full     = w_full;
   assign bus.count    = r_count;
   assign bus.stall    = w_stall;
   assign bus.rx_total = r_rx_total;
endmodule

// File: tb/tb_periph_handshake_rx.sv
// Scoreboard bench for periph_handshake_rx: captured words are queued on send and checked on pop.
// Build with PERIPH_ACCUM_EN defined to also exercise acc_sum.
module tb_periph_handshake_rx;
   logic clk = 1'b0;
   logic clk_snd = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_fail = 0;
   logic [15:0] q[$];
   logic [15:0] exp_total = '0;
   logic [15:0] exp_acc = '0;

   always #8  clk = ~clk;
   always #10 clk_snd = ~clk_snd;

   periph_handshake_rx_if #(.DW(16), .AW(2)) bus ();

   periph_handshake_rx #(.DW(16), .DEPTH(4), .AW(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ack(input logic lvl, input string tag);
      int n = 0;
      while (bus.ack !== lvl && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk(tag, bus.ack, lvl);
   endtask

   task automatic note_word(input logic [15:0] d);
      q.push_back(d);
      exp_total = exp_total + 16'd1;
      exp_acc   = exp_acc + d;
   endtask

   // one full 4-phase transfer driven from the unrelated 20 ns clock
   task automatic send_word(input logic [15:0] d);
      @(posedge clk_snd);
      bus.dado = d;
      bus.send = 1'b1;
      note_word(d);
      wait_ack(1'b1, "ack_rise");
      @(posedge clk_snd);
      bus.send = 1'b0;
      wait_ack(1'b0, "ack_fall");
   endtask

   task automatic pop_chk();
      logic [15:0] e;
      @(negedge clk);
      chk("pop_nonempty", bus.empty, 1'b0);
      e = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
      chk("rd_data", bus.rd_data, e);
      bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
   endtask

   initial begin
      int maxcnt;
      int got;
      bus.dado  = 16'hFFFF;
      bus.send  = 1'b1;
      bus.rd_en = 1'b0;
      rst       = 1'b0;

      // reset with send already high
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ack", bus.ack, 1'b0);
      chk("rst_empty", bus.empty, 1'b1);
      chk("rst_full", bus.full, 1'b0);
      chk("rst_count", bus.count, 0);
      chk("rst_stall", bus.stall, 1'b0);
      chk("rst_total", bus.rx_total, 0);
      chk("rst_rd_data", bus.rd_data, 0);
`ifdef PERIPH_ACCUM_EN
      chk("rst_acc", bus.acc_sum, 0);
`endif
      rst = 1'b1;
      note_word(16'hFFFF);
      @(posedge clk); #1 chk("rel_e1_ack", bus.ack, 1'b0);
      @(posedge clk); #1 chk("rel_e2_ack", bus.ack, 1'b0);
      @(posedge clk); #1 chk("rel_e3_ack", bus.ack, 1'b1);
      @(negedge clk);
      bus.send = 1'b0;
      wait_ack(1'b0, "rel_ack_fall");
      chk("rel_total", bus.rx_total, exp_total);
      pop_chk();

      // single transfer with exact edge latency
      @(negedge clk);
      bus.dado = 16'h1234;
      bus.send = 1'b1;
      note_word(16'h1234);
      @(posedge clk); #1 chk("t2_e1_ack", bus.ack, 1'b0);
      @(posedge clk); #1 chk("t2_e2_ack", bus.ack, 1'b0);
      @(posedge clk); #1 chk("t2_e3_ack", bus.ack, 1'b1);
      chk("t2_count", bus.count, 1);
      chk("t2_rd_data", bus.rd_data, 16'h1234);
      @(negedge clk);
      bus.send = 1'b0;
      @(posedge clk); #1 chk("t2_f1_ack", bus.ack, 1'b1);
      @(posedge clk); #1 chk("t2_f2_ack", bus.ack, 1'b1);
      @(posedge clk); #1 chk("t2_f3_ack", bus.ack, 1'b0);
      pop_chk();

      // send held long: one write only
      @(negedge clk);
      bus.dado = 16'h5A5A;
      bus.send = 1'b1;
      note_word(16'h5A5A);
      repeat (20) @(posedge clk);
      #1;
      chk("hold_count", bus.count, 1);
      chk("hold_total", bus.rx_total, exp_total);
      chk("hold_ack", bus.ack, 1'b1);
      bus.send = 1'b0;
      wait_ack(1'b0, "hold_ack_fall");
      chk("hold_count2", bus.count, 1);
      pop_chk();

      // fill, then backpressure
      for (int i = 0; i < 4; i++) send_word(16'hA000 + 16'(i));
      @(negedge clk);
      chk("bp_full", bus.full, 1'b1);
      chk("bp_count", bus.count, 4);
      @(posedge clk_snd);
      bus.dado = 16'hA004;
      bus.send = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("bp_stall", bus.stall, 1'b1);
      chk("bp_ack", bus.ack, 1'b0);
      chk("bp_count_held", bus.count, 4);
      chk("bp_total_held", bus.rx_total, exp_total);
      note_word(16'hA004);
      pop_chk();
      wait_ack(1'b1, "bp_ack_rise");
      chk("bp_stall_clr", bus.stall, 1'b0);
      chk("bp_count_after", bus.count, 4);
      chk("bp_next_head", bus.rd_data, 16'hA001);
      @(posedge clk_snd);
      bus.send = 1'b0;
      wait_ack(1'b0, "bp_ack_fall");
      for (int i = 0; i < 4; i++) pop_chk();
      chk("bp_drained", bus.empty, 1'b1);

      // streaming with rd_en held high, including while empty
      maxcnt = 0;
      got = 0;
      fork
         begin
            for (int i = 1; i <= 10; i++) send_word(16'(i));
         end
         begin
            int cyc = 0;
            logic [15:0] e;
            while (got < 10 && cyc < 3000) begin
               @(negedge clk);
               cyc++;
               if (int'(bus.count) > maxcnt) maxcnt = int'(bus.count);
               if (!bus.empty) begin
                  e = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
                  chk("wrap_rd_data", bus.rd_data, e);
                  got++;
               end
               bus.rd_en = 1'b1;
            end
            chk("wrap_got_all", got, 10);
         end
      join
      repeat (5) @(negedge clk);
      chk("wrap_max_le2", (maxcnt <= 2), 1);
      chk("wrap_empty_rd_count", bus.count, 0);
      chk("wrap_empty_rd_empty", bus.empty, 1'b1);
      chk("wrap_total", bus.rx_total, exp_total);
      bus.rd_en = 1'b0;
`ifdef PERIPH_ACCUM_EN
      chk("acc_running", bus.acc_sum, exp_acc);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      q.delete();
      exp_total = '0;
      exp_acc = '0;
      send_word(16'hFFFF);
      send_word(16'h0002);
      chk("acc_wrap", bus.acc_sum, 16'h0001);
`endif

      // reset during ACK
      @(negedge clk);
      bus.dado = 16'h7777;
      bus.send = 1'b1;
      wait_ack(1'b1, "mid_ack_rise");
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("mid_rst_ack", bus.ack, 1'b0);
      chk("mid_rst_count", bus.count, 0);
      chk("mid_rst_empty", bus.empty, 1'b1);
      chk("mid_rst_total", bus.rx_total, 0);
`ifdef PERIPH_ACCUM_EN
      chk("mid_rst_acc", bus.acc_sum, 0);
`endif
      q.delete();
      bus.send = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_rst_ack", bus.ack, 1'b0);
      chk("post_rst_empty", bus.empty, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
